// File: rtl/alu16_pkg.sv
// Shared constants and the opcode encoding for the 16-bit ALU.
package alu16_pkg;

    localparam int unsigned ALU16_W = 16;

    typedef enum logic [3:0] {
        OpAdd   = 4'h0,
        OpSub   = 4'h1,
        OpAnd   = 4'h2,
        OpOr    = 4'h3,
        OpXor   = 4'h4,
        OpNot   = 4'h5,
        OpShl   = 4'h6,
        OpShr   = 4'h7,
        OpAsr   = 4'h8,
        OpRol   = 4'h9,
        OpRor   = 4'hA,
        OpMul   = 4'hB,
        OpSlt   = 4'hC,
        OpSltu  = 4'hD,
        OpPass2 = 4'hE,
        OpPass1 = 4'hF
    } alu16_op_e;

endpackage

// File: rtl/alu16_adder.sv
// Ripple-carry adder built from per-bit full-adder equations.
// Shared by ADD, SUB and the signed/unsigned comparisons.
module alu16_adder
    import alu16_pkg::*;
(
    input  logic [ALU16_W-1:0] a,
    input  logic [ALU16_W-1:0] b,
    input  logic               cin,
    output logic [ALU16_W-1:0] sum,
    output logic               cout
);

    logic [ALU16_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < ALU16_W; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[ALU16_W];

endmodule

// File: rtl/alu16.sv
// 16-bit registered ALU, one-cycle latency, 16 opcodes.
// Define ALU16_MUL_EN to build the multiplier for opcode 0xB; without it
// that opcode returns zero and no multiplier is synthesised.
module alu16
    import alu16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ALU16_W-1:0] op1,
    input  logic [ALU16_W-1:0] op2,
    input  logic [3:0]         select,
    output logic [ALU16_W-1:0] result
);

    logic [ALU16_W-1:0] add_b;
    logic               add_cin;
    logic [ALU16_W-1:0] add_sum;
    logic               add_cout;
    logic               ovf;
    logic               slt_lt;
    logic               sltu_lt;
    logic [3:0]         sh;
    logic [4:0]         sh_inv;
    logic [ALU16_W-1:0] result_d;
    logic [ALU16_W-1:0] result_q;

    // Only ADD adds; every other adder user wants op1 - op2 = op1 + ~op2 + 1.
    always_comb begin
        add_b   = ~op2;
        add_cin = 1'b1;
        if (select == OpAdd) begin
            add_b   = op2;
            add_cin = 1'b0;
        end
    end

    alu16_adder u_adder (
        .a    (op1),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Signed less-than is sign xor overflow; unsigned less-than is a borrow (no carry).
    assign ovf     = (op1[ALU16_W-1] ^ op2[ALU16_W-1]) & (add_sum[ALU16_W-1] ^ op1[ALU16_W-1]);
    assign slt_lt  = add_sum[ALU16_W-1] ^ ovf;
    assign sltu_lt = ~add_cout;

    assign sh     = op2[3:0];
    // Shift by 16 yields zero, so rotate by 0 degenerates cleanly to op1.
    assign sh_inv = 5'd16 - {1'b0, sh};

    // Operation decode.
    always_comb begin
        result_d = '0;
        unique case (alu16_op_e'(select))
            OpAdd:   result_d = add_sum;
            OpSub:   result_d = add_sum;
            OpAnd:   result_d = op1 & op2;
            OpOr:    result_d = op1 | op2;
            OpXor:   result_d = op1 ^ op2;
            OpNot:   result_d = ~op1;
            OpShl:   result_d = op1 << sh;
            OpShr:   result_d = op1 >> sh;
            OpAsr:   result_d = $signed(op1) >>> sh;
            OpRol:   result_d = (op1 << sh) | (op1 >> sh_inv);
            OpRor:   result_d = (op1 >> sh) | (op1 << sh_inv);
`ifdef ALU16_MUL_EN
            OpMul:   result_d = op1 * op2;
`else
            OpMul:   result_d = '0;
`endif
            OpSlt:   result_d = {{(ALU16_W - 1){1'b0}}, slt_lt};
            OpSltu:  result_d = {{(ALU16_W - 1){1'b0}}, sltu_lt};
            OpPass2: result_d = op2;
            OpPass1: result_d = op1;
        endcase
    end

    // Result register; reset clears it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed vectors plus a randomised sweep,
// expected values queued at drive time and checked one edge later.
module tb_alu16;

    logic        clk;
    logic        rst_n;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  select;
    logic [15:0] result;

    int total;
    int bad;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    alu16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .op1    (op1),
        .op2    (op2),
        .select (select),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model(input logic [3:0] s, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] r;
        logic [31:0] p;
        r = 16'h0;
        case (s)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: r = a << b[3:0];
            4'h7: r = a >> b[3:0];
            4'h8: r = 16'($signed(a) >>> b[3:0]);
            4'h9: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) r = {r[14:0], r[15]};
            end
            4'hA: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) r = {r[0], r[15:1]};
            end
            4'hB: begin
`ifdef ALU16_MUL_EN
                p = 32'(a) * 32'(b);
                r = p[15:0];
`else
                p = 32'h0;
                r = p[15:0];
`endif
            end
            4'hC: r = ($signed(a) < $signed(b)) ? 16'h1 : 16'h0;
            4'hD: r = (a < b) ? 16'h1 : 16'h0;
            4'hE: r = b;
            default: r = a;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, queue the expectation, check just after the rising edge.
    task automatic step(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string tag);
        logic [15:0] e;
        string       t;
        @(negedge clk);
        select = s;
        op1    = a;
        op2    = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 16'h1, 16'h0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, result, e);
        end
    endtask

    initial begin
        logic [3:0]  rs;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] mul_exp;

        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        select = 4'h0;
        op1    = 16'h0005;
        op2    = 16'h0003;

        // Reset holds result at zero, even across a clock edge.
        #3;
        check("reset_initial", result, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_hold_edge", result, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        step(4'h0, 16'h0005, 16'h0003, 16'h0008, "add_basic");
        step(4'h0, 16'hFFFF, 16'h0001, 16'h0000, "add_wrap");
        step(4'h1, 16'h0003, 16'h0005, 16'hFFFE, "sub_neg");
        step(4'hC, 16'h0003, 16'h0005, 16'h0001, "slt_small");
        step(4'hC, 16'h8000, 16'h0001, 16'h0001, "slt_negative");
        step(4'hD, 16'h8000, 16'h0001, 16'h0000, "sltu_big");
        step(4'hC, 16'h7FFF, 16'h8000, 16'h0000, "slt_ovf");
        step(4'hD, 16'h1234, 16'h1234, 16'h0000, "sltu_equal");
        step(4'hF, 16'h00AB, 16'h1234, 16'h00AB, "pass1");
        step(4'hE, 16'h00AB, 16'h1234, 16'h1234, "pass2");
        step(4'h7, 16'h8000, 16'h0004, 16'h0800, "shr");
        step(4'h8, 16'h8000, 16'h0004, 16'hF800, "asr");
        step(4'h9, 16'h8001, 16'h0001, 16'h0003, "rol");
        step(4'hA, 16'h8001, 16'h0001, 16'hC000, "ror");
        step(4'h6, 16'h1234, 16'hFFF0, 16'h1234, "shl_zero_amt");
        step(4'h9, 16'hA5C3, 16'h0010, 16'hA5C3, "rol_zero_amt");
        step(4'h6, 16'h0001, 16'h000F, 16'h8000, "shl_max");
        step(4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, "and");
        step(4'h3, 16'hF0F0, 16'h3C3C, 16'hFCFC, "or");
        step(4'h4, 16'hF0F0, 16'h3C3C, 16'hCCCC, "xor");
        step(4'h5, 16'hF0F0, 16'h3C3C, 16'h0F0F, "not");
`ifdef ALU16_MUL_EN
        mul_exp = 16'h0100;
`else
        mul_exp = 16'h0000;
`endif
        step(4'hB, 16'h0100, 16'h0101, mul_exp, "mul");

        // Randomised sweep against the reference model.
        for (int i = 0; i < 64; i++) begin
            rs = 4'(i);
            ra = 16'($urandom);
            rb = 16'($urandom);
            step(rs, ra, rb, model(rs, ra, rb), $sformatf("rand_op%0h", rs));
        end

        // Reset between edges while ADD 1+1 is running.
        step(4'h0, 16'h0001, 16'h0001, 16'h0002, "add_before_reset");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", result, 16'h0000);
        @(posedge clk);
        #1;
        check("async_reset_hold", result, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'h0, 16'h0001, 16'h0001, 16'h0002, "add_after_reset");

        check("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
